// File: rtl/vga2_pkg.sv
// rtl/vga2_pkg.sv - shared span types, arbiter states and screen default for the vga2 span path
package vga2_pkg;

    localparam int DEFAULT_SCREEN_WIDTH = 640;

    typedef struct packed {
        logic [15:0] x1;
        logic [15:0] x2;
        logic [31:0] z;
        logic [31:0] dzdx;
        logic [31:0] u;
        logic [31:0] dudx;
        logic [31:0] v;
        logic [31:0] dvdx;
    } span_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } span_arb_state_t;

endpackage

// File: rtl/vga2_rr_pick.sv
// rtl/vga2_rr_pick.sv - combinational round-robin picker: first valid index at or after ptr, wrapping
module vga2_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [PW-1:0]      grant_o,
    output logic               any_o
);

    // Scan from farthest to nearest so the nearest valid index overwrites last.
    always_comb begin
        grant_o = '0;
        any_o   = |valid_i;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (valid_i[(int'(ptr_i) + i) % NUM_REQ]) begin
                grant_o = PW'((int'(ptr_i) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/vga2_span_arbiter.sv
// rtl/vga2_span_arbiter.sv - round-robin span arbiter with drop/clamp and per-line start/drain barrier
module vga2_span_arbiter
    import vga2_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int SCREEN_WIDTH = DEFAULT_SCREEN_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      line_start,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ-1:0][15:0]  req_x1,
    input  logic [NUM_REQ-1:0][15:0]  req_x2,
    input  logic [NUM_REQ-1:0][31:0]  req_z,
    input  logic [NUM_REQ-1:0][31:0]  req_dzdx,
    input  logic [NUM_REQ-1:0][31:0]  req_u,
    input  logic [NUM_REQ-1:0][31:0]  req_dudx,
    input  logic [NUM_REQ-1:0][31:0]  req_v,
    input  logic [NUM_REQ-1:0][31:0]  req_dvdx,
    output logic                      scanline_valid,
    input  logic                      scanline_ready,
    output logic [15:0]               scanline_x1,
    output logic [15:0]               scanline_x2,
    output logic [31:0]               scanline_z,
    output logic [31:0]               scanline_dzdx,
    output logic [31:0]               scanline_u,
    output logic [31:0]               scanline_dudx,
    output logic [31:0]               scanline_v,
    output logic [31:0]               scanline_dvdx,
    input  logic                      scanline_busy,
    output logic                      line_done,
    output logic                      line_overrun,
    output logic [15:0]               drop_count
);

    localparam int PW = $clog2(NUM_REQ);
    localparam logic [15:0] WIDTH16 = 16'(SCREEN_WIDTH);

    span_arb_state_t   state_q, state_d;
    logic [NUM_REQ-1:0] finished_q, finished_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              out_valid_q, out_valid_d;
    span_t             out_span_q, out_span_d;
    logic [15:0]       drop_count_q, drop_count_d;
    logic              overrun_q;

    logic [NUM_REQ-1:0] eligible;
    logic [PW-1:0]      grant;
    logic               any_eligible;
    logic               stage_free;
    logic               accept;
    span_t              beat;
    logic               beat_last;
    logic               beat_drop;

    assign eligible   = req_valid & ~finished_q;
    assign stage_free = !out_valid_q || scanline_ready;
    assign accept     = (state_q == ARB) && any_eligible && stage_free;

    vga2_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .valid_i (eligible),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .any_o   (any_eligible)
    );

    always_comb begin
        beat.x1   = req_x1[grant];
        beat.x2   = req_x2[grant];
        beat.z    = req_z[grant];
        beat.dzdx = req_dzdx[grant];
        beat.u    = req_u[grant];
        beat.dudx = req_dudx[grant];
        beat.v    = req_v[grant];
        beat.dvdx = req_dvdx[grant];
        beat_last = req_last[grant];
        beat_drop = (beat.x1 >= beat.x2) || (beat.x1 >= WIDTH16);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The barrier sees the marker accepted this cycle, hence finished_d rather than finished_q.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (line_start) state_d = ARB;
            ARB:     if (&finished_d) state_d = DRAIN;
            DRAIN:   if (!out_valid_q && !scanline_busy) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
        line_done = (state_q == DONE);
    end

    always_comb begin
        finished_d   = finished_q;
        rr_ptr_d     = rr_ptr_q;
        out_valid_d  = out_valid_q && !scanline_ready;
        out_span_d   = out_span_q;
        drop_count_d = drop_count_q;
        if (state_q == IDLE) begin
            finished_d = '0;
        end
        if (accept) begin
            rr_ptr_d = (grant == PW'(NUM_REQ - 1)) ? '0 : grant + PW'(1);
            if (beat_last) begin
                finished_d[grant] = 1'b1;
            end else if (beat_drop) begin
                if (drop_count_q != 16'hFFFF) begin
                    drop_count_d = drop_count_q + 16'd1;
                end
            end else begin
                out_valid_d = 1'b1;
                out_span_d  = beat;
                if (beat.x2 > WIDTH16) begin
                    out_span_d.x2 = WIDTH16;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            finished_q   <= '0;
            rr_ptr_q     <= '0;
            out_valid_q  <= 1'b0;
            out_span_q   <= '0;
            drop_count_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            finished_q   <= finished_d;
            rr_ptr_q     <= rr_ptr_d;
            out_valid_q  <= out_valid_d;
            out_span_q   <= out_span_d;
            drop_count_q <= drop_count_d;
            overrun_q    <= line_start && (state_q != IDLE);
        end
    end

    assign scanline_valid = out_valid_q;
    assign scanline_x1    = out_span_q.x1;
    assign scanline_x2    = out_span_q.x2;
    assign scanline_z     = out_span_q.z;
    assign scanline_dzdx  = out_span_q.dzdx;
    assign scanline_u     = out_span_q.u;
    assign scanline_dudx  = out_span_q.dudx;
    assign scanline_v     = out_span_q.v;
    assign scanline_dvdx  = out_span_q.dvdx;
    assign line_overrun   = overrun_q;
    assign drop_count     = drop_count_q;

endmodule

// File: tb/tb_vga2_span_arbiter.sv
// tb/tb_vga2_span_arbiter.sv - self-checking bench for vga2_span_arbiter
module tb_vga2_span_arbiter;
    import vga2_pkg::*;

    localparam int N = 2;
    localparam int W = 640;
    localparam int P_IDLE = 0, P_ARB = 1, P_DRAIN = 2, P_DONE = 3;

    logic clock = 1'b0;
    logic reset, line_start;
    logic [N-1:0] req_valid, req_ready, req_last;
    logic [N-1:0][15:0] req_x1, req_x2;
    logic [N-1:0][31:0] req_z, req_dzdx, req_u, req_dudx, req_v, req_dvdx;
    logic scanline_valid, scanline_ready, scanline_busy;
    logic [15:0] scanline_x1, scanline_x2;
    logic [31:0] scanline_z, scanline_dzdx, scanline_u, scanline_dudx, scanline_v, scanline_dvdx;
    logic line_done, line_overrun;
    logic [15:0] drop_count;

    always #5 clock = ~clock;

    vga2_span_arbiter #(.NUM_REQ(N), .SCREEN_WIDTH(W)) dut (
        .clock(clock), .reset(reset), .line_start(line_start),
        .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
        .req_x1(req_x1), .req_x2(req_x2), .req_z(req_z), .req_dzdx(req_dzdx),
        .req_u(req_u), .req_dudx(req_dudx), .req_v(req_v), .req_dvdx(req_dvdx),
        .scanline_valid(scanline_valid), .scanline_ready(scanline_ready),
        .scanline_x1(scanline_x1), .scanline_x2(scanline_x2), .scanline_z(scanline_z),
        .scanline_dzdx(scanline_dzdx), .scanline_u(scanline_u), .scanline_dudx(scanline_dudx),
        .scanline_v(scanline_v), .scanline_dvdx(scanline_dvdx),
        .scanline_busy(scanline_busy), .line_done(line_done),
        .line_overrun(line_overrun), .drop_count(drop_count)
    );

    typedef struct { bit last; span_t s; } beat_t;
    typedef struct { logic [15:0] x1; logic [15:0] x2; bit issue; logic [15:0] x2_exp; int drops; } vec_t;

    beat_t rq[N][$];
    int    m_phase, m_rr, m_drops, n_done, dut_done, cyc;
    bit    m_fin[N];
    bit    m_overrun;
    span_t m_stage[$];
    logic [31:0] issued[$];
    int    issued_cyc[$];
    logic [N-1:0] last_req_ready;
    bit    rand_mode;
    int    n_checks, n_fail;
    vec_t  tbl[10];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic span_t rnd_span(input logic [15:0] x1, input logic [15:0] x2, input logic [31:0] z);
        span_t s;
        s.x1 = x1; s.x2 = x2; s.z = z;
        s.dzdx = $urandom; s.u = $urandom; s.dudx = $urandom; s.v = $urandom; s.dvdx = $urandom;
        return s;
    endfunction

    function automatic span_t dut_span();
        span_t s;
        s.x1 = scanline_x1; s.x2 = scanline_x2; s.z = scanline_z; s.dzdx = scanline_dzdx;
        s.u = scanline_u; s.dudx = scanline_dudx; s.v = scanline_v; s.dvdx = scanline_dvdx;
        return s;
    endfunction

    function automatic bit all_fin();
        foreach (m_fin[i]) if (!m_fin[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_span(input int r, input int x1, input int x2, input int z);
        beat_t b;
        b.last = 1'b0;
        b.s = rnd_span(16'(x1), 16'(x2), 32'(z));
        rq[r].push_back(b);
    endtask

    task automatic push_last(input int r);
        beat_t b;
        b.last = 1'b1;
        b.s = rnd_span(16'($urandom), 16'($urandom), $urandom);
        rq[r].push_back(b);
    endtask

    task automatic drive(input int r, input span_t s);
        req_x1[r] = s.x1; req_x2[r] = s.x2; req_z[r] = s.z; req_dzdx[r] = s.dzdx;
        req_u[r] = s.u; req_dudx[r] = s.dudx; req_v[r] = s.v; req_dvdx[r] = s.dvdx;
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_rr = 0; m_drops = 0; m_overrun = 1'b0;
        foreach (m_fin[i]) m_fin[i] = 1'b0;
        m_stage.delete();
    endtask

    // One clock: drive requesters, compare against the model, advance the model, step the clock.
    task automatic cycle();
        int g;
        bit acc, old_empty;
        beat_t b;
        span_t s;
        logic [N-1:0] exp_ready;
        if (rand_mode) begin
            scanline_ready = ($urandom_range(0, 2) != 0);
            scanline_busy  = ($urandom_range(0, 1) != 0);
            if (m_phase != P_IDLE && $urandom_range(0, 29) == 0) line_start = 1'b1;
        end
        for (int r = 0; r < N; r++) begin
            if (rq[r].size() != 0 && (!rand_mode || $urandom_range(0, 3) != 0)) begin
                req_valid[r] = 1'b1; req_last[r] = rq[r][0].last; drive(r, rq[r][0].s);
            end else begin
                req_valid[r] = 1'b0; req_last[r] = 1'($urandom);
                drive(r, rnd_span(16'($urandom), 16'($urandom), $urandom));
            end
        end
        #1;
        g = -1;
        for (int off = 0; off < N; off++) begin
            int idx = (m_rr + off) % N;
            if (g < 0 && req_valid[idx] && !m_fin[idx]) g = idx;
        end
        acc = (m_phase == P_ARB) && (g >= 0) && (m_stage.size() == 0 || scanline_ready);
        exp_ready = acc ? N'(1 << g) : '0;
        last_req_ready = req_ready;
        chk("req_ready", 256'(req_ready), 256'(exp_ready));
        chk("scanline_valid", 256'(scanline_valid), 256'(m_stage.size() != 0));
        if (m_stage.size() != 0) chk("scanline_data", 256'(dut_span()), 256'(m_stage[0]));
        chk("line_done", 256'(line_done), 256'(m_phase == P_DONE));
        chk("line_overrun", 256'(line_overrun), 256'(m_overrun));
        chk("drop_count", 256'(drop_count), 256'(m_drops));
        if (scanline_valid === 1'b1 && scanline_ready) begin
            issued.push_back(scanline_z);
            issued_cyc.push_back(cyc);
        end
        if (line_done === 1'b1) dut_done++;
        if (m_phase == P_DONE) n_done++;
        old_empty = (m_stage.size() == 0);
        if (!old_empty && scanline_ready) s = m_stage.pop_front();
        if (acc) begin
            b = rq[g].pop_front();
            m_rr = (g + 1) % N;
            if (b.last) m_fin[g] = 1'b1;
            else if (b.s.x1 >= b.s.x2 || b.s.x1 >= W) begin
                if (m_drops < 65535) m_drops++;
            end else begin
                s = b.s;
                if (s.x2 > W) s.x2 = 16'(W);
                m_stage.push_back(s);
            end
        end
        m_overrun = line_start && (m_phase != P_IDLE);
        case (m_phase)
            P_IDLE:  if (line_start) begin m_phase = P_ARB; foreach (m_fin[i]) m_fin[i] = 1'b0; end
            P_ARB:   if (all_fin()) m_phase = P_DRAIN;
            P_DRAIN: if (old_empty && !scanline_busy) m_phase = P_DONE;
            default: m_phase = P_IDLE;
        endcase
        @(posedge clock); #1;
        line_start = 1'b0;
        cyc++;
    endtask

    task automatic run_until_done(input string name, input int budget);
        int start = n_done;
        int k = 0;
        while (n_done == start && k < budget) begin
            cycle();
            k++;
        end
        chk(name, 256'(n_done - start), 256'(1));
    endtask

    initial begin
        int s0;
        logic [31:0] held_z;
        tbl[0] = '{16'd30,  16'd30,    1'b0, 16'd0,   1};
        tbl[1] = '{16'd700, 16'd710,   1'b0, 16'd0,   2};
        tbl[2] = '{16'd600, 16'd900,   1'b1, 16'd640, 2};
        tbl[3] = '{16'd10,  16'd20,    1'b1, 16'd20,  2};
        tbl[4] = '{16'd639, 16'd640,   1'b1, 16'd640, 2};
        tbl[5] = '{16'd640, 16'd641,   1'b0, 16'd0,   3};
        tbl[6] = '{16'd5,   16'd3,     1'b0, 16'd0,   4};
        tbl[7] = '{16'd0,   16'd65535, 1'b1, 16'd640, 4};
        tbl[8] = '{16'd100, 16'd641,   1'b1, 16'd640, 4};
        tbl[9] = '{16'd639, 16'd639,   1'b0, 16'd0,   5};

        reset = 1'b1; line_start = 1'b0; req_valid = '0; req_last = '0;
        for (int r = 0; r < N; r++) drive(r, rnd_span(16'd0, 16'd0, 32'd0));
        scanline_ready = 1'b0; scanline_busy = 1'b0; rand_mode = 1'b0;
        n_checks = 0; n_fail = 0; n_done = 0; dut_done = 0; cyc = 0;
        model_reset();
        #12;
        chk("rst_scanline_valid", 256'(scanline_valid), 256'(0));
        chk("rst_req_ready", 256'(req_ready), 256'(0));
        chk("rst_line_done", 256'(line_done), 256'(0));
        chk("rst_line_overrun", 256'(line_overrun), 256'(0));
        chk("rst_drop_count", 256'(drop_count), 256'(0));
        chk("rst_scanline_data", 256'(dut_span()), 256'(0));
        reset = 1'b0;
        @(posedge clock); #1;

        // Round-robin fairness: two streams interleave at one fragment per cycle.
        scanline_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin push_span(0, 10, 20, k); push_span(1, 10, 20, 16 + k); end
        push_last(0); push_last(1);
        issued.delete(); issued_cyc.delete();
        line_start = 1'b1;
        run_until_done("rr_line_done", 60);
        chk("rr_count", 256'(issued.size()), 256'(8));
        for (int i = 0; i < 8 && i < issued.size(); i++) begin
            chk($sformatf("rr_order[%0d]", i), 256'(issued[i]), 256'((i % 2 == 0) ? i / 2 : 16 + i / 2));
            if (i > 0) chk($sformatf("rr_gap[%0d]", i), 256'(issued_cyc[i] - issued_cyc[i-1]), 256'(1));
        end

        // Drop and clamp vectors, one beat at a time from requester 0.
        line_start = 1'b1;
        cycle();
        for (int i = 0; i < 10; i++) begin
            push_span(0, int'(tbl[i].x1), int'(tbl[i].x2), 400 + i);
            cycle();
            chk($sformatf("tbl_valid[%0d]", i), 256'(scanline_valid), 256'(tbl[i].issue));
            if (tbl[i].issue) chk($sformatf("tbl_x2[%0d]", i), 256'(scanline_x2), 256'(tbl[i].x2_exp));
            chk($sformatf("tbl_drops[%0d]", i), 256'(drop_count), 256'(tbl[i].drops));
        end
        push_last(0); push_last(1);
        run_until_done("tbl_line_done", 40);

        // Backpressure: output held stable and nothing accepted while the stepper stalls.
        push_span(0, 50, 60, 200); push_span(0, 70, 80, 202);
        line_start = 1'b1;
        cycle();
        scanline_ready = 1'b0;
        cycle();
        held_z = 32'd200;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_hold_valid", 256'(scanline_valid), 256'(1));
            chk("bp_hold_z", 256'(scanline_z), 256'(held_z));
            chk("bp_ready_low", 256'(last_req_ready), 256'(0));
        end
        scanline_ready = 1'b1;
        cycle();
        chk("bp_next_valid", 256'(scanline_valid), 256'(1));
        chk("bp_next_z", 256'(scanline_z), 256'(202));
        push_last(0); push_last(1);
        run_until_done("bp_line_done", 40);

        // Barrier with a stepper that stays busy, plus an overrun line_start during DRAIN.
        push_last(0);
        push_span(1, 1, 9, 500); push_span(1, 2, 9, 501); push_last(1);
        scanline_busy = 1'b1;
        s0 = dut_done;
        line_start = 1'b1;
        for (int k = 0; k < 20 && m_phase != P_DRAIN; k++) cycle();
        for (int k = 0; k < 8; k++) begin
            if (k == 2) line_start = 1'b1;
            cycle();
            if (k == 2) chk("overrun_pulse", 256'(line_overrun), 256'(1));
        end
        chk("barrier_no_early_done", 256'(dut_done - s0), 256'(0));
        scanline_busy = 1'b0;
        run_until_done("barrier_line_done", 10);
        repeat (3) cycle();
        chk("barrier_done_once", 256'(dut_done - s0), 256'(1));

        // Asynchronous reset mid-line with a pending fragment.
        line_start = 1'b1;
        cycle();
        push_span(0, 30, 30, 299); push_span(0, 10, 20, 300);
        scanline_ready = 1'b0;
        cycle(); cycle();
        chk("arst_pre_valid", 256'(scanline_valid), 256'(1));
        #2 reset = 1'b1;
        #1;
        chk("arst_valid_drop", 256'(scanline_valid), 256'(0));
        chk("arst_drop_count", 256'(drop_count), 256'(0));
        chk("arst_line_done", 256'(line_done), 256'(0));
        model_reset();
        foreach (rq[r]) rq[r].delete();
        #2 reset = 1'b0;
        s0 = dut_done;
        push_span(0, 10, 20, 301);
        scanline_ready = 1'b1;
        repeat (10) cycle();
        chk("arst_no_done", 256'(dut_done - s0), 256'(0));
        foreach (rq[r]) rq[r].delete();

        // Randomized lines against the reference model.
        rand_mode = 1'b1;
        for (int ln = 0; ln < 25; ln++) begin
            for (int r = 0; r < N; r++) begin
                int ns = $urandom_range(0, 4);
                for (int k = 0; k < ns; k++)
                    push_span(r, $urandom_range(0, 700), $urandom_range(0, 900), $urandom);
                push_last(r);
            end
            line_start = 1'b1;
            run_until_done($sformatf("rand_line_done[%0d]", ln), 400);
            foreach (rq[r]) rq[r].delete();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga2_span_arbiter.md
# vga2_span_arbiter

Shares the single `vga2_scanline` span stepper between `NUM_REQ` object processors. It accepts span fragments under round-robin arbitration and drops empty or off-screen spans. It clamps the right edge to the screen and registers the winner into the stepper's ready/valid port. For each display line it runs a start/drain barrier, so the Z-buffer swap logic gets a single `line_done` pulse once every requester has finished the line and the stepper has emitted its last pixel.

## Interface
- `NUM_REQ`, 2: number of object-processor requesters (2..4).
- `SCREEN_WIDTH`, 640: visible pixels per line; x2 is clamped to this value.

- `clock` in 1: single system clock.
- `reset` in 1: asynchronous, active-high.
- `line_start` in 1: one-cycle pulse from display timing; opens a new line.
- `req_valid` in NUM_REQ: per-requester beat valid.
- `req_ready` out NUM_REQ: per-requester beat accepted.
- `req_last` in NUM_REQ: beat is an end-of-line marker; its data is ignored.
- `req_x1`, `req_x2` in NUM_REQ×16: unsigned integer left (inclusive) and right (exclusive) edges.
- `req_z`, `req_dzdx`, `req_u`, `req_dudx`, `req_v`, `req_dvdx` in NUM_REQ×32: 16.16 start values and slopes.
- `scanline_valid` out 1: fragment valid to the stepper.
- `scanline_ready` in 1: stepper ready.
- `scanline_x1`, `scanline_x2` out 16: forwarded edges; x2 is clamped.
- `scanline_z`, `scanline_dzdx`, `scanline_u`, `scanline_dudx`, `scanline_v`, `scanline_dvdx` out 32: forwarded unchanged.
- `scanline_busy` in 1: stepper still emitting pixels for an accepted fragment.
- `line_done` out 1: one-cycle pulse when the line is fully drained.
- `line_overrun` out 1: one-cycle pulse when `line_start` arrives outside IDLE.
- `drop_count` out 16: saturating count of dropped fragments since reset.

## Operation
- **States:**
  - IDLE: waits for `line_start`. All `req_ready` are 0.
  - ARB: accepts beats from requesters.
  - DRAIN: no acceptance.
  - DONE: pulses `line_done`, then returns to IDLE.
- **Line start:** entering ARB clears `finished[NUM_REQ]`.
- **Arbitration in ARB:**
  - Eligible set is `req_valid & ~finished`.
  - Grant is the first eligible index at or after `rr_ptr`, wrapping.
  - `req_ready[g]` = 1 iff output stage is empty or `scanline_ready`. All other ready bits are 0.
- **On an accepted beat:**
  - `rr_ptr` ← g+1 mod NUM_REQ.
  - If `req_last`: set `finished[g]`; nothing is issued.
  - Else if x1 ≥ x2 or x1 ≥ SCREEN_WIDTH: drop the fragment and increment `drop_count`, saturating at 0xFFFF.
  - Else: load the output stage, with x2' = min(x2, SCREEN_WIDTH).
- **Leaving ARB:** ARB→DRAIN when all `finished` bits are set. This includes the cycle in which the last marker is accepted.
- **Drain:** DRAIN→DONE when the output stage is empty and `scanline_busy`=0.
- **Line overrun:** `line_start` in ARB, DRAIN or DONE is ignored for sequencing and pulses `line_overrun` on the next cycle.
- **Output stage:** one registered entry. `scanline_valid` is held with stable data until `scanline_ready`.

## Timing
- Reset values:
  - All outputs are 0.
  - state = IDLE, `rr_ptr` = 0, `finished` = 0, output stage empty.
- Reset mid-line discards any pending fragment. No `line_done` is produced for that line.
- Latency: a beat accepted in cycle n gives `scanline_valid` in cycle n+1.
- Throughput: one fragment per cycle while `scanline_ready` is held at 1.
- Simultaneous `scanline_ready` and a new accept: the output register reloads in the same edge, with no bubble.
- `req_ready` depends combinationally on `req_valid`, `finished`, `rr_ptr`, state, output-stage occupancy and `scanline_ready`. There is no combinational path from any `req_*` data input.
- `line_done` is asserted for exactly the one cycle spent in DONE. The earliest it can occur is 2 cycles after the final marker is accepted.
- A requester that never sends `req_last` holds the line open indefinitely. There is no timeout.

## Structure
- Package `vga2_pkg` holds:
  - `span_t` struct (x1, x2, z, dzdx, u, dudx, v, dvdx).
  - `span_arb_state_t` enum (IDLE, ARB, DRAIN, DONE).
  - `SCREEN_WIDTH` default.
- Sub-module `vga2_rr_pick`: combinational round-robin picker over NUM_REQ, returning grant index and any-valid.
- Everything else is in `vga2_span_arbiter`.

## Test plan
- **Round-robin fairness:** NUM_REQ=2; both requesters stream 4 spans x1=10, x2=20 with `scanline_ready`=1 → output order is r0,r1,r0,r1,… at one per cycle; `rr_ptr` alternates.
- **Drop and clamp:** span (30,30) → dropped, `drop_count`=1. Span (700,710) → dropped, `drop_count`=2. Span (600,900) → issued with x2=640.
- **Backpressure:** `scanline_ready` held at 0 for 5 cycles with `scanline_valid`=1 → data is stable and `req_ready`=0 throughout; release → next span issued in the following cycle.
- **Barrier:** r0 sends last, r1 sends 2 spans then last, `scanline_busy` stays 1 for 8 cycles after → `line_done` pulses once, only after busy falls.
- **Overrun:** `line_start` during DRAIN → `line_overrun` pulses, state is unchanged, `line_done` still pulses once.
- **Async reset:** reset asserted mid-ARB with a pending fragment → `scanline_valid` drops immediately, state = IDLE, and no `line_done` appears.
